reset_sequencer: RTL and testbench

- Central reset controller for one clock domain.
- Holds all downstream reset domains in reset until the synchronized PLL/MMCM lock is stable, then waits a programmable hold time and releases the domains one at a time, in index order, with a fixed gap between releases.
- Re-enters the sequence on loss of lock or on a software reset request.
- Sits after the board reset path. Its domain_reset outputs feed reset_sync instances in each consumer domain.

---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/data_sync.sv | 20 ++
 rtl/reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_reset_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// lock-loss counter width and a small sizing helper.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;

  localparam int LOCK_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/data_sync.sv
// Multi-flop synchronizer for slow level signals crossing into clk.
// The flops carry no reset so the chain tracks its input from power-up.
module data_sync #(
  parameter int SYNC_STAGE = 2,
  parameter int WIDTH      = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGE-1:0][WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    sync_reg <= {sync_reg[SYNC_STAGE-2:0], d};
  end

  assign q = sync_reg[SYNC_STAGE-1];

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: qualifies PLL lock, holds, then releases the
// downstream reset domains one by one; restarts on lock loss or sw_reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 8,
  parameter int LOCK_FILTER     = 4,
  parameter int LOCK_SYNC_STAGE = 3
) (
  input  logic                   clk,
  input  logic                   async_reset,
  input  logic                   pll_locked,
  input  logic                   sw_reset,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_released,
  output logic [2:0]             seq_state,
  output logic [LOCK_CNT_W-1:0]  lock_loss_count
);

  // One counter serves filter, hold and gap timing since the states are exclusive.
  localparam int CNT_MAX = max3(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [NUM_DOMAINS-1:0] ALL_RESET = '1;

  logic lock_s;

  seq_state_e                 state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  logic [NUM_DOMAINS-1:0]     domain_reset_reg, domain_reset_next;
  logic                       all_released_reg, all_released_next;
  logic [LOCK_CNT_W-1:0]      lock_loss_count_reg, lock_loss_count_next;
  logic [NUM_DOMAINS-1:0]     release_shift;
  logic                       release_step;
  logic                       sequencing;

  data_sync #(
    .SYNC_STAGE (LOCK_SYNC_STAGE),
    .WIDTH      (1)
  ) u_lock_sync (
    .clk (clk),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Released bits are zeros growing up from bit 0, so a left shift frees the next one.
  assign release_shift = domain_reset_reg << 1;
  assign sequencing    = (state_reg == ST_HOLD) || (state_reg == ST_RELEASE) ||
                         (state_reg == ST_RUN);

  always_comb begin
    state_next           = state_reg;
    cnt_next             = cnt_reg;
    domain_reset_next    = domain_reset_reg;
    all_released_next    = all_released_reg;
    lock_loss_count_next = lock_loss_count_reg;
    release_step         = 1'b0;

    case (state_reg)
      ST_RESET: begin
        state_next = ST_WAIT_LOCK;
        cnt_next   = '0;
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_next = '0;
        end else if (cnt_reg == FILTER_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_reg == HOLD_LAST) release_step = 1'b1;
        else                      cnt_next = cnt_reg + CNT_W'(1);
      end
      ST_RELEASE: begin
        if (cnt_reg == GAP_LAST) release_step = 1'b1;
        else                     cnt_next = cnt_reg + CNT_W'(1);
      end
      ST_RUN: begin
      end
      default: begin
        state_next        = ST_WAIT_LOCK;
        cnt_next          = '0;
        domain_reset_next = ALL_RESET;
        all_released_next = 1'b0;
      end
    endcase

    if (release_step) begin
      cnt_next          = '0;
      domain_reset_next = release_shift;
      if (release_shift == '0) begin
        state_next        = ST_RUN;
        all_released_next = 1'b1;
      end else begin
        state_next = ST_RELEASE;
      end
    end

    // Lock loss outranks sw_reset and is the only path that bumps the counter.
    if (sequencing) begin
      if (!lock_s) begin
        state_next        = ST_WAIT_LOCK;
        cnt_next          = '0;
        domain_reset_next = ALL_RESET;
        all_released_next = 1'b0;
        if (lock_loss_count_reg != '1) begin
          lock_loss_count_next = lock_loss_count_reg + LOCK_CNT_W'(1);
        end
      end else if (sw_reset) begin
        state_next        = ST_HOLD;
        cnt_next          = '0;
        domain_reset_next = ALL_RESET;
        all_released_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_reg           <= ST_RESET;
      cnt_reg             <= '0;
      domain_reset_reg    <= ALL_RESET;
      all_released_reg    <= 1'b0;
      lock_loss_count_reg <= '0;
    end else begin
      state_reg           <= state_next;
      cnt_reg             <= cnt_next;
      domain_reset_reg    <= domain_reset_next;
      all_released_reg    <= all_released_next;
      lock_loss_count_reg <= lock_loss_count_next;
    end
  end

  assign domain_reset    = domain_reset_reg;
  assign all_released    = all_released_reg;
  assign seq_state       = state_reg;
  assign lock_loss_count = lock_loss_count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 4-domain build and a 1-domain build
// share stimulus; expectations are edge counts derived from default timing.
module tb_reset_sequencer;

  localparam int GAP = 8;
  localparam int HLD = 16;

  logic       clk;
  logic       async_reset;
  logic       pll_locked;
  logic       sw_reset;
  logic [3:0] domain_reset;
  logic       all_released;
  logic [2:0] seq_state;
  logic [7:0] lock_loss_count;
  logic [0:0] domain_reset_1;
  logic       all_released_1;
  logic [2:0] seq_state_1;
  logic [7:0] lock_loss_count_1;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(.NUM_DOMAINS(4)) dut (
    .clk             (clk),
    .async_reset     (async_reset),
    .pll_locked      (pll_locked),
    .sw_reset        (sw_reset),
    .domain_reset    (domain_reset),
    .all_released    (all_released),
    .seq_state       (seq_state),
    .lock_loss_count (lock_loss_count)
  );

  reset_sequencer #(.NUM_DOMAINS(1)) dut_1 (
    .clk             (clk),
    .async_reset     (async_reset),
    .pll_locked      (pll_locked),
    .sw_reset        (sw_reset),
    .domain_reset    (domain_reset_1),
    .all_released    (all_released_1),
    .seq_state       (seq_state_1),
    .lock_loss_count (lock_loss_count_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows a release sequence where domain 0 falls on relative edge d0.
  task automatic follow(input string tag, input int d0, input int nticks);
    logic [3:0] exp_dr;
    logic [2:0] exp_st;
    for (int k = 1; k <= nticks; k++) begin
      tick();
      exp_dr = 4'hF;
      for (int i = 0; i < 4; i++) if (k >= d0 + GAP * i) exp_dr[i] = 1'b0;
      if (k < d0 - HLD)          exp_st = 3'd1;
      else if (k < d0)           exp_st = 3'd2;
      else if (k < d0 + 3 * GAP) exp_st = 3'd3;
      else                       exp_st = 3'd4;
      check_val({tag, "_dr"}, 32'(domain_reset), 32'(exp_dr));
      check_val({tag, "_ar"}, 32'(all_released), 32'(k >= d0 + 3 * GAP));
      check_val({tag, "_st"}, 32'(seq_state), 32'(exp_st));
      check_val({tag, "_dr1"}, 32'(domain_reset_1), 32'(k < d0));
      check_val({tag, "_ar1"}, 32'(all_released_1), 32'(k >= d0));
    end
    $display("phase %s done checks=%0d", tag, checks);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_dr"}, 32'(domain_reset), 32'h0000000F);
    check_val({tag, "_ar"}, 32'(all_released), 32'h0);
    check_val({tag, "_st"}, 32'(seq_state), 32'h0);
    check_val({tag, "_cnt"}, 32'(lock_loss_count), 32'h0);
    check_val({tag, "_dr1"}, 32'(domain_reset_1), 32'h1);
    check_val({tag, "_ar1"}, 32'(all_released_1), 32'h0);
  endtask

  initial begin
    int exp_cnt;
    async_reset = 1'b1;
    pll_locked  = 1'b1;
    sw_reset    = 1'b0;
    repeat (5) tick();
    check_reset_values("rst");

    // Lock already stable: domains fall at edges 21/29/37/45.
    async_reset = 1'b0;
    follow("boot", 21, 46);
    check_val("boot_cnt", 32'(lock_loss_count), 32'h0);

    // Lock loss in RUN: seen by the FSM on the 4th edge after pll drops.
    pll_locked = 1'b0;
    repeat (3) tick();
    check_val("loss_still_run", 32'(seq_state), 32'h4);
    check_val("loss_still_dr", 32'(domain_reset), 32'h0);
    tick();
    check_val("loss_dr", 32'(domain_reset), 32'hF);
    check_val("loss_ar", 32'(all_released), 32'h0);
    check_val("loss_st", 32'(seq_state), 32'h1);
    check_val("loss_cnt", 32'(lock_loss_count), 32'h1);
    repeat (6) tick();

    // sw_reset has no effect while waiting for lock.
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    check_val("sw_wait_st", 32'(seq_state), 32'h1);
    check_val("sw_wait_dr", 32'(domain_reset), 32'hF);

    // Lock glitch 1,1,0,0 then steady: filter must restart, no loss counted.
    pll_locked = 1'b1;
    repeat (2) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    follow("relock", 23, 23 + GAP + 2);
    check_val("relock_cnt", 32'(lock_loss_count), 32'h1);

    // sw_reset after domain 1 released: back to HOLD, domain 0 falls 16 edges on.
    check_val("pre_sw_dr", 32'(domain_reset), 32'hC);
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    check_val("sw_dr", 32'(domain_reset), 32'hF);
    check_val("sw_st", 32'(seq_state), 32'h2);
    check_val("sw_ar", 32'(all_released), 32'h0);
    follow("swrst", HLD, HLD + 3 * GAP + 1);

    // Lock loss and sw_reset together: lock loss wins.
    pll_locked = 1'b0;
    repeat (3) tick();
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    check_val("both_st", 32'(seq_state), 32'h1);
    check_val("both_dr", 32'(domain_reset), 32'hF);
    check_val("both_cnt", 32'(lock_loss_count), 32'h2);

    // 300 lock/loss cycles, one loss each: count saturates at 255.
    for (int p = 1; p <= 300; p++) begin
      pll_locked = 1'b1;
      repeat (8) tick();
      pll_locked = 1'b0;
      repeat (4) tick();
      exp_cnt = (2 + p > 255) ? 255 : 2 + p;
      if (p % 50 == 1 || (p >= 251 && p <= 255) || p == 300)
        check_val("sat_cnt", 32'(lock_loss_count), 32'(exp_cnt));
    end
    $display("phase saturate done checks=%0d", checks);

    // async_reset mid-RELEASE returns to reset values without a clock edge.
    pll_locked = 1'b1;
    follow("pre_ar", 23, 23 + GAP + 2);
    #2;
    async_reset = 1'b1;
    #1;
    check_reset_values("ar");
    repeat (3) tick();
    check_reset_values("ar_held");
    async_reset = 1'b0;
    follow("after_ar", 21, 46);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
